// File: rtl/lighting_pkg.sv
// Shared types and sizing helpers for the lamp turn-on scheduler.
package lighting_pkg;

  typedef enum logic {S_IDLE, S_HOLDOFF} sched_state_e;

  // Width of the stagger counter; it must hold STAGGER_T-1 and never be zero bits wide.
  function automatic int cnt_width(input int stagger_t);
    return (stagger_t <= 2) ? 1 : $clog2(stagger_t);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: first set request at or after ptr (mod N) wins.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic found;
  int   j;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    j         = 0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!found && req[j]) begin
        found     = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = IW'(j);
      end
    end
  end

endmodule

// File: rtl/lamp_scheduler.sv
// Staggered lamp turn-on sequencer with a cap on simultaneously lit zones.
// Define LAMP_SCHED_FIXED_PRIO_EN for fixed (lowest index first) priority instead of round-robin.
module lamp_scheduler
  import lighting_pkg::*;
#(
  parameter int N_ZONES   = 4,
  parameter int STAGGER_T = 1000,
  parameter int MAX_ON    = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_ZONES-1:0]           req,
  output logic [N_ZONES-1:0]           lamp_en,
  output logic [N_ZONES-1:0]           pending,
  output logic [$clog2(N_ZONES+1)-1:0] on_count,
  output logic                         holdoff
);

  localparam int IW  = $clog2(N_ZONES);
  localparam int CW  = cnt_width(STAGGER_T);
  localparam int OCW = $clog2(N_ZONES + 1);

  sched_state_e       state;
  logic [CW-1:0]      cnt;
  logic [IW-1:0]      ptr;
  logic [N_ZONES-1:0] win_oh;
  logic [IW-1:0]      win_idx;
  logic               grant;
  logic [N_ZONES-1:0] lamp_nxt;
  logic [OCW-1:0]     on_nxt;

  assign pending = req & ~lamp_en;
  assign holdoff = (state == S_HOLDOFF);

`ifdef LAMP_SCHED_FIXED_PRIO_EN
  assign ptr = '0;
`else
  logic [IW-1:0] last_grant;

  assign ptr = (last_grant == IW'(N_ZONES - 1)) ? '0 : last_grant + IW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        last_grant <= IW'(N_ZONES - 1);
    else if (grant) last_grant <= win_idx;
  end
`endif

  rr_arbiter #(.N(N_ZONES), .IW(IW)) u_arb (
    .req       (pending),
    .ptr       (ptr),
    .grant     (win_oh),
    .grant_idx (win_idx)
  );

  // Slot check uses the registered count, so a same-edge turn-off frees nothing until the next edge.
  assign grant    = (state == S_IDLE) && (|pending) && (int'(on_count) < MAX_ON);
  assign lamp_nxt = (lamp_en & req) | (grant ? win_oh : '0);

  always_comb begin
    on_nxt = '0;
    for (int i = 0; i < N_ZONES; i++) on_nxt = on_nxt + OCW'(lamp_nxt[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      lamp_en  <= '0;
      on_count <= '0;
    end else begin
      lamp_en  <= lamp_nxt;
      on_count <= on_nxt;
      case (state)
        S_IDLE: begin
          if (grant) begin
            cnt   <= CW'(STAGGER_T - 1);
            state <= (STAGGER_T > 1) ? S_HOLDOFF : S_IDLE;
          end
        end
        S_HOLDOFF: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
